// File: rtl/bm_sched_pkg.sv
// rtl/bm_sched_pkg.sv - shared types and constants for the block-matching frame scheduler
package bm_sched_pkg;

  typedef enum logic [1:0] {
    SCH_IDLE     = 2'd0,
    SCH_DISPATCH = 2'd1,
    SCH_DRAIN    = 2'd2,
    SCH_DONE     = 2'd3
  } sched_state_t;

  // Rows per band; the engines use the same value to turn a band index into a row range.
  localparam int BAND_ROWS = 16;

endpackage

// File: rtl/bm_engine_picker.sv
// rtl/bm_engine_picker.sv - engine busy tracking and lowest-free-engine grant
module bm_engine_picker
  import bm_sched_pkg::*;
#(
  parameter int NUM_ENGINES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_ENGINES-1:0] set_i,
  input  logic [NUM_ENGINES-1:0] done_i,
  output logic [NUM_ENGINES-1:0] grant_o,
  output logic                   any_busy_o,
  output logic                   any_free_o,
  output logic                   stray_done_o
);

  logic [NUM_ENGINES-1:0] busy_q;
  logic [NUM_ENGINES-1:0] busy_d;

  // Done clears, dispatch sets; set only ever targets a free engine so the two never collide.
  always_comb begin
    busy_d = (busy_q & ~done_i) | set_i;
  end

  // Busy flag register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // One-hot grant of the lowest-index free engine, scanning downward so the lowest wins.
  always_comb begin
    grant_o = '0;
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
      end
    end
  end

  assign any_busy_o   = |busy_q;
  assign any_free_o   = ~&busy_q;
  assign stray_done_o = |(done_i & ~busy_q);

endmodule

// File: rtl/bm_frame_scheduler.sv
// rtl/bm_frame_scheduler.sv - frame detection and band dispatch to block-matching engines
module bm_frame_scheduler
  import bm_sched_pkg::*;
#(
  parameter int NUM_ENGINES = 2,
  parameter int NUM_BANDS   = 30,
  parameter int IMG_W       = 4,
  localparam int BAND_W     = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [IMG_W-1:0]       image_number,
  output logic                   bm_idle,
  output logic                   bm_working_buf,
  output logic [NUM_ENGINES-1:0] job_start,
  output logic [BAND_W-1:0]      job_band,
  output logic                   job_buf,
  input  logic [NUM_ENGINES-1:0] job_done,
  output logic                   frame_done,
  output logic [IMG_W-1:0]       frames_done,
  output logic                   overrun,
  output logic                   proto_err
);

  localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(NUM_BANDS - 1);

  sched_state_t           state_q, state_d;
  logic [IMG_W-1:0]       seen_img_q, seen_img_d;
  logic                   work_buf_q, work_buf_d;
  logic                   bm_idle_q, bm_idle_d;
  logic [BAND_W-1:0]      next_band_q, next_band_d;
  logic [NUM_ENGINES-1:0] job_start_q, job_start_d;
  logic [BAND_W-1:0]      job_band_q, job_band_d;
  logic                   job_buf_q, job_buf_d;
  logic                   frame_done_q, frame_done_d;
  logic [IMG_W-1:0]       frames_done_q, frames_done_d;
  logic                   overrun_q, overrun_d;
  logic                   proto_err_q, proto_err_d;

  logic [NUM_ENGINES-1:0] grant;
  logic [NUM_ENGINES-1:0] set_engines;
  logic                   any_busy;
  logic                   any_free;
  logic                   stray_done;
  logic                   pending;
  logic [IMG_W-1:0]       img_delta;

  assign pending     = (image_number != seen_img_q);
  assign img_delta   = image_number - seen_img_q;
  assign set_engines = ((state_q == SCH_DISPATCH) && any_free) ? grant : '0;

  bm_engine_picker #(
    .NUM_ENGINES (NUM_ENGINES)
  ) u_picker (
    .clk          (clk),
    .reset_n      (reset_n),
    .set_i        (set_engines),
    .done_i       (job_done),
    .grant_o      (grant),
    .any_busy_o   (any_busy),
    .any_free_o   (any_free),
    .stray_done_o (stray_done)
  );

  // Next-state and registered-output decode for the frame sequencing FSM.
  always_comb begin
    state_d       = state_q;
    seen_img_d    = seen_img_q;
    work_buf_d    = work_buf_q;
    bm_idle_d     = bm_idle_q;
    next_band_d   = next_band_q;
    job_start_d   = '0;
    job_band_d    = job_band_q;
    job_buf_d     = job_buf_q;
    frame_done_d  = 1'b0;
    frames_done_d = frames_done_q;
    overrun_d     = overrun_q;
    proto_err_d   = proto_err_q | stray_done;

    case (state_q)
      SCH_IDLE: begin
        if (pending) begin
          // The writer fills buffer 0 first, so the just-completed buffer is the opposite of the count's LSB.
          seen_img_d  = image_number;
          work_buf_d  = ~image_number[0];
          next_band_d = '0;
          bm_idle_d   = 1'b0;
          state_d     = SCH_DISPATCH;
          if (img_delta > IMG_W'(1)) begin
            overrun_d = 1'b1;
          end
        end
      end
      SCH_DISPATCH: begin
        if (any_free) begin
          job_start_d = grant;
          job_band_d  = next_band_q;
          job_buf_d   = work_buf_q;
          if (next_band_q == LAST_BAND) begin
            state_d = SCH_DRAIN;
          end else begin
            next_band_d = next_band_q + 1'b1;
          end
        end
      end
      SCH_DRAIN: begin
        if (!any_busy) begin
          state_d = SCH_DONE;
        end
      end
      SCH_DONE: begin
        frame_done_d  = 1'b1;
        frames_done_d = frames_done_q + 1'b1;
        bm_idle_d     = 1'b1;
        state_d       = SCH_IDLE;
      end
      default: begin
        state_d = SCH_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= SCH_IDLE;
      seen_img_q    <= '0;
      work_buf_q    <= 1'b0;
      bm_idle_q     <= 1'b1;
      next_band_q   <= '0;
      job_start_q   <= '0;
      job_band_q    <= '0;
      job_buf_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      frames_done_q <= '0;
      overrun_q     <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      seen_img_q    <= seen_img_d;
      work_buf_q    <= work_buf_d;
      bm_idle_q     <= bm_idle_d;
      next_band_q   <= next_band_d;
      job_start_q   <= job_start_d;
      job_band_q    <= job_band_d;
      job_buf_q     <= job_buf_d;
      frame_done_q  <= frame_done_d;
      frames_done_q <= frames_done_d;
      overrun_q     <= overrun_d;
      proto_err_q   <= proto_err_d;
    end
  end

  assign bm_idle        = bm_idle_q;
  assign bm_working_buf = work_buf_q;
  assign job_start      = job_start_q;
  assign job_band       = job_band_q;
  assign job_buf        = job_buf_q;
  assign frame_done     = frame_done_q;
  assign frames_done    = frames_done_q;
  assign overrun        = overrun_q;
  assign proto_err      = proto_err_q;

endmodule

// File: tb/tb_bm_frame_scheduler.sv
// tb/tb_bm_frame_scheduler.sv - scoreboard bench for the block-matching frame scheduler
module tb_bm_frame_scheduler;

  localparam int NE = 2;
  localparam int NB = 30;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [IW-1:0] image_number;
  logic          bm_idle;
  logic          bm_working_buf;
  logic [NE-1:0] job_start;
  logic [4:0]    job_band;
  logic          job_buf;
  logic [NE-1:0] job_done = '0;
  logic          frame_done;
  logic [IW-1:0] frames_done;
  logic          overrun;
  logic          proto_err;

  int checks = 0;
  int errors = 0;
  int start_count = 0;
  int exp_frames = 0;

  typedef struct {
    int band;
    int bufv;
    int eng;
  } exp_t;
  exp_t sb[$];
  exp_t got;

  // Engine models: latency per engine (0 = never completes), plus a manual kick per engine.
  int            lat [NE];
  int            cnt [NE];
  logic [NE-1:0] kick;

  always #5 clk = ~clk;

  bm_frame_scheduler #(
    .NUM_ENGINES (NE),
    .NUM_BANDS   (NB),
    .IMG_W       (IW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .image_number   (image_number),
    .bm_idle        (bm_idle),
    .bm_working_buf (bm_working_buf),
    .job_start      (job_start),
    .job_band       (job_band),
    .job_buf        (job_buf),
    .job_done       (job_done),
    .frame_done     (frame_done),
    .frames_done    (frames_done),
    .overrun        (overrun),
    .proto_err      (proto_err)
  );

  always @(negedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NE; i++) cnt[i] = 0;
      job_done = '0;
    end else begin
      for (int i = 0; i < NE; i++) begin
        job_done[i] = 1'b0;
        if (cnt[i] > 0) begin
          cnt[i] = cnt[i] - 1;
          if (cnt[i] == 0) job_done[i] = 1'b1;
        end
        if (kick[i]) job_done[i] = 1'b1;
        if (job_start[i]) cnt[i] = lat[i];
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && job_start !== '0) begin
      start_count++;
      checks++;
      if ($countones(job_start) != 1) begin
        errors++;
        $display("FAIL job_start_onehot got=%b required one bit", job_start);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_job got band=%0d buf=%0d required no job", job_band, job_buf);
      end else begin
        got = sb.pop_front();
        if (job_band !== 5'(got.band) || job_buf !== 1'(got.bufv)) begin
          errors++;
          $display("FAIL job_fields got band=%0d buf=%0d required band=%0d buf=%0d",
                   job_band, job_buf, got.band, got.bufv);
        end
        if (got.eng >= 0) begin
          checks++;
          if (job_start !== 2'(1 << got.eng)) begin
            errors++;
            $display("FAIL job_engine band=%0d got=%b required engine %0d", got.band, job_start, got.eng);
          end
        end
      end
    end
  end

  task automatic push_frame(input int bufv, input bit stuck);
    exp_t e;
    for (int b = 0; b < NB; b++) begin
      e.band = b;
      e.bufv = bufv;
      e.eng  = stuck ? ((b == 1) ? 1 : 0) : -1;
      sb.push_back(e);
    end
    start_count = 0;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    image_number = '0;
    kick         = '0;
    repeat (2) @(negedge clk);
    sb.delete();
    exp_frames = 0;
    reset_n    = 1'b1;
  endtask

  task automatic finish_frame(input string name);
    int n = 0;
    while (frame_done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    exp_frames++;
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL %s_frame_done_timeout got=%b required 1 within 2000 cycles", name, frame_done);
    end else if (start_count != NB || sb.size() != 0 || frames_done !== 4'(exp_frames) || bm_idle !== 1'b1) begin
      errors++;
      $display("FAIL %s_frame_end got starts=%0d left=%0d frames=%0d idle=%b required starts=%0d left=0 frames=%0d idle=1",
               name, start_count, sb.size(), frames_done, bm_idle, NB, exp_frames[IW-1:0]);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_frame_done_width got=%b required 0", name, frame_done);
    end
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    image_number = '0;
    kick         = '0;
    lat[0] = 5;
    lat[1] = 5;
    repeat (2) @(negedge clk);
    checks++;
    if ({bm_idle, bm_working_buf, job_start, job_band, job_buf, frame_done, frames_done, overrun, proto_err} !==
        {1'b1, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values got idle=%b wb=%b js=%b band=%0d buf=%b fd=%b fds=%0d ov=%b pe=%b required 1 0 00 0 0 0 0 0 0",
               bm_idle, bm_working_buf, job_start, job_band, job_buf, frame_done, frames_done, overrun, proto_err);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_frame();
    push_frame(0, 1'b0);
    image_number = 4'd1;
    @(negedge clk);
    checks++;
    if (bm_idle !== 1'b0 || bm_working_buf !== 1'b0) begin
      errors++;
      $display("FAIL first_idle_drop got idle=%b wb=%b required idle=0 wb=0", bm_idle, bm_working_buf);
    end
    @(negedge clk);
    checks++;
    if (job_start !== 2'b01 || job_band !== 5'd0 || job_buf !== 1'b0) begin
      errors++;
      $display("FAIL first_job got js=%b band=%0d buf=%b required js=01 band=0 buf=0", job_start, job_band, job_buf);
    end
    @(negedge clk);
    checks++;
    if (job_start !== 2'b10 || job_band !== 5'd1) begin
      errors++;
      $display("FAIL second_job got js=%b band=%0d required js=10 band=1", job_start, job_band);
    end
    finish_frame("frame1");
  endtask

  task automatic test_buffers();
    push_frame(1, 1'b0);
    image_number = 4'd2;
    @(negedge clk);
    checks++;
    if (bm_working_buf !== 1'b1) begin
      errors++;
      $display("FAIL frame2_buf got=%b required 1", bm_working_buf);
    end
    finish_frame("frame2");
    push_frame(0, 1'b0);
    image_number = 4'd3;
    @(negedge clk);
    checks++;
    if (bm_working_buf !== 1'b0) begin
      errors++;
      $display("FAIL frame3_buf got=%b required 0", bm_working_buf);
    end
    finish_frame("frame3");
  endtask

  task automatic test_stuck_engine();
    int n    = 0;
    bit seen = 1'b0;
    lat[0] = 1;
    lat[1] = 0;
    push_frame(1, 1'b1);
    image_number = 4'd4;
    while (start_count < NB && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (start_count != NB) begin
      errors++;
      $display("FAIL stuck_dispatch got starts=%0d required %0d", start_count, NB);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (frame_done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen || bm_idle !== 1'b0) begin
      errors++;
      $display("FAIL stuck_drain_hold got frame_done_seen=%b idle=%b required 0 0", seen, bm_idle);
    end
    @(posedge clk);
    #1 kick[1] = 1'b1;
    @(negedge clk);
    #1 kick[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (frame_done === 1'b1) seen = 1'b1;
    end
    @(negedge clk);
    exp_frames++;
    checks++;
    if (seen || frame_done !== 1'b1 || frames_done !== 4'(exp_frames) || bm_idle !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL stuck_frame_done got early=%b fd=%b frames=%0d idle=%b left=%0d required 0 1 %0d 1 0",
               seen, frame_done, frames_done, bm_idle, sb.size(), exp_frames);
    end
    @(negedge clk);
    lat[0] = 5;
    lat[1] = 5;
  endtask

  task automatic test_overrun();
    do_reset();
    @(negedge clk);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear got=%b required 0", overrun);
    end
    push_frame(1, 1'b0);
    image_number = 4'd2;
    @(negedge clk);
    checks++;
    if (overrun !== 1'b1 || bm_working_buf !== 1'b1) begin
      errors++;
      $display("FAIL overrun_jump got ov=%b wb=%b required ov=1 wb=1", overrun, bm_working_buf);
    end
    finish_frame("overrun");
  endtask

  task automatic test_proto_err();
    checks++;
    if (proto_err !== 1'b0) begin
      errors++;
      $display("FAIL proto_err_clear got=%b required 0", proto_err);
    end
    @(posedge clk);
    #1 kick[0] = 1'b1;
    @(negedge clk);
    #1 kick[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (proto_err !== 1'b1 || bm_idle !== 1'b1) begin
      errors++;
      $display("FAIL proto_err_set got pe=%b idle=%b required pe=1 idle=1", proto_err, bm_idle);
    end
  endtask

  task automatic test_reset_mid_dispatch();
    push_frame(0, 1'b0);
    image_number = 4'd3;
    repeat (6) @(negedge clk);
    checks++;
    if (start_count == 0 || bm_idle !== 1'b0) begin
      errors++;
      $display("FAIL mid_frame_running got starts=%0d idle=%b required >0 0", start_count, bm_idle);
    end
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bm_idle, bm_working_buf, job_start, job_band, job_buf, frame_done, frames_done, overrun, proto_err} !==
        {1'b1, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got idle=%b wb=%b js=%b band=%0d buf=%b fd=%b fds=%0d ov=%b pe=%b required 1 0 00 0 0 0 0 0 0",
               bm_idle, bm_working_buf, job_start, job_band, job_buf, frame_done, frames_done, overrun, proto_err);
    end
    do_reset();
    @(negedge clk);
    push_frame(0, 1'b0);
    image_number = 4'd1;
    finish_frame("after_reset");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_frame();
    test_buffers();
    test_stuck_engine();
    test_overrun();
    test_proto_err();
    test_reset_mid_dispatch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
